ctrl_mux_sched: RTL and testbench
=================================

CTRL_MUX_SCHED -- requirements
Module: ctrl_mux_sched

Interface
REQ-001 Parameter S_COUNT, default 2, number of mux input ports (2..16).
REQ-002 Parameter SELECTOR_WIDTH, default $clog2(S_COUNT), selector token width.
REQ-003 Parameter PEND_WIDTH, default 4, per-port pending-frame counter width; max pending = 2^PEND_WIDTH-1.
REQ-004 Parameter WEIGHT, default 4, max consecutive grants to one port while others are pending (1..255).
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 s_req_valid  input  S_COUNT  per-port frame-arrival event, one accepted beat per frame.
REQ-008 s_req_ready  output  S_COUNT  per-port accept; low when that port's pending counter is at max.
REQ-009 m_sel_tdata  output  SELECTOR_WIDTH  granted port index, drives the mux selector stream.
REQ-010 m_sel_tvalid  output  1  selector token valid.
REQ-011 m_sel_tready  input  1  selector token consumed; the mux asserts it on a frame's last beat.
REQ-012 pending_cnt  output  S_COUNT*PEND_WIDTH  current pending count per port, port i at [i*PEND_WIDTH +: PEND_WIDTH].
REQ-013 stat_idx  input  SELECTOR_WIDTH, and stat_grants  output  32; present only with SCHED_STATS_EN.

Function
REQ-014 Per-port counter pending[i] SHALL increment on s_req_valid[i]&&s_req_ready[i] and decrement on selector handshake for port i; when both occur in the same cycle, the counter SHALL be unchanged.
REQ-015 s_req_ready[i] SHALL be combinationally (pending[i] != max); it SHALL NOT depend on s_req_valid.
REQ-016 FSM SHALL have two states: IDLE (m_sel_tvalid=0) and OFFER (m_sel_tvalid=1).
REQ-017 In IDLE with any pending[i]>0, the scheduler SHALL pick a port, register it into m_sel_tdata and go to OFFER next cycle; with all zero, it SHALL stay in IDLE.
REQ-018 Pick rule: if pending[last]>0 and burst<WEIGHT, pick last; otherwise pick the first port with pending>0 searching last+1, last+2, ... modulo S_COUNT, including last itself as the final candidate.
REQ-019 In OFFER, m_sel_tdata and m_sel_tvalid SHALL remain stable until m_sel_tready; on handshake: pending[sel] decrements, burst = (sel==last) ? burst+1 : 1, last = sel, and the state returns to IDLE.
REQ-020 Latency: event accepted in cycle N with all pending zero and IDLE -> m_sel_tvalid high in cycle N+2; peak throughput one token per 2 cycles.
REQ-021 burst SHALL saturate at WEIGHT and never wrap; pending SHALL never underflow, since a token is only offered for a port with pending>=1.
REQ-022 A port with pending at max SHALL keep s_req_ready low until its token handshakes; during that handshake cycle s_req_ready is still low.

Reset
REQ-023 On rst: state IDLE, m_sel_tvalid=0, m_sel_tdata=0, all pending=0, last=S_COUNT-1, burst=0, s_req_ready all 1 from the next cycle, stat counters=0.
REQ-024 rst asserted during OFFER SHALL drop m_sel_tvalid the next cycle and discard the outstanding token; any simultaneous req or tready SHALL be ignored.

Configuration
REQ-025 Macro SCHED_STATS_EN: when defined, a 32-bit wrapping grant counter per port increments on each handshake for that port, and stat_grants = counter[stat_idx] combinationally (0 for stat_idx>=S_COUNT); when undefined, the counters, stat_idx and stat_grants SHALL be absent and the behaviour otherwise identical.

Verification
REQ-026 Single event on port 1 after reset: req at cycle 5 -> tvalid at cycle 7, tdata=1; tready at cycle 9 -> pending[1]=0, tvalid=0 at cycle 10.
REQ-027 S_COUNT=2, WEIGHT=4, ports 0 and 1 each loaded with 6 events, tready always 1 -> token order 0,0,0,0,1,1,1,1,0,0,1,1.
REQ-028 PEND_WIDTH=4, tready=0, 16 events on port 0 -> 15 accepted, s_req_ready[0]=0 after the 15th; one handshake -> ready returns the following cycle.
REQ-029 Port 2 at pending=3 in OFFER with tdata=2: req[2] and tready in the same cycle -> pending[2] stays 3.
REQ-030 rst pulsed while OFFER with tdata=1 -> tvalid=0 and all pending_cnt=0 the next cycle; no token re-offered.
REQ-031 With SCHED_STATS_EN, after the REQ-027 sequence, stat_idx=0 -> stat_grants=6, and stat_idx=1 -> stat_grants=6.

Source files
------------

// File: rtl/ctrl_mux_sched_if.sv
// Handshake bundle between the frame-arrival/selector-stream side and ctrl_mux_sched.
// The scheduler is the slave; whoever produces events and consumes tokens is the master.
interface ctrl_mux_sched_if #(
    parameter int S_COUNT        = 2,
    parameter int SELECTOR_WIDTH = $clog2(S_COUNT),
    parameter int PEND_WIDTH     = 4
);
    logic [S_COUNT-1:0]            s_req_valid;
    logic [S_COUNT-1:0]            s_req_ready;
    logic [SELECTOR_WIDTH-1:0]     m_sel_tdata;
    logic                          m_sel_tvalid;
    logic                          m_sel_tready;
    logic [S_COUNT*PEND_WIDTH-1:0] pending_cnt;

    modport master (
        output s_req_valid, m_sel_tready,
        input  s_req_ready, m_sel_tdata, m_sel_tvalid, pending_cnt
    );

    modport slave (
        input  s_req_valid, m_sel_tready,
        output s_req_ready, m_sel_tdata, m_sel_tvalid, pending_cnt
    );
endinterface

// File: rtl/ctrl_mux_sched.sv
// Weighted round-robin selector scheduler: counts pending frames per port and offers one
// selector token at a time. Optional per-port grant statistics under SCHED_STATS_EN.
module ctrl_mux_sched #(
    parameter int S_COUNT        = 2,
    parameter int SELECTOR_WIDTH = $clog2(S_COUNT),
    parameter int PEND_WIDTH     = 4,
    parameter int WEIGHT         = 4
) (
    input logic             clk,
    input logic             rst,
    ctrl_mux_sched_if.slave sched_if
`ifdef SCHED_STATS_EN
    ,
    input  logic [SELECTOR_WIDTH-1:0] stat_idx,
    output logic [31:0]               stat_grants
`endif
);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [7:0]            WEIGHT_B = 8'(WEIGHT);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                    state_q;
    logic                      tvalid_q;
    logic [SELECTOR_WIDTH-1:0] sel_q;
    logic [SELECTOR_WIDTH-1:0] last_q;
    logic [7:0]                burst_q;
    logic [PEND_WIDTH-1:0]     pend_q [S_COUNT];

    logic [S_COUNT-1:0]        nonzero;
    logic [S_COUNT-1:0]        accept;
    logic [S_COUNT-1:0]        grant;
    logic [SELECTOR_WIDTH-1:0] pick_d;
    logic                      handshake;

    assign handshake             = tvalid_q & sched_if.m_sel_tready;
    assign sched_if.m_sel_tvalid = tvalid_q;
    assign sched_if.m_sel_tdata  = sel_q;

    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
        assign sched_if.s_req_ready[gi] = (pend_q[gi] != PEND_MAX);
        assign accept[gi]  = sched_if.s_req_valid[gi] & sched_if.s_req_ready[gi];
        assign grant[gi]   = handshake && (sel_q == SELECTOR_WIDTH'(gi));
        assign nonzero[gi] = (pend_q[gi] != '0);
        assign sched_if.pending_cnt[gi*PEND_WIDTH +: PEND_WIDTH] = pend_q[gi];

        // An arrival and a grant in the same cycle cancel out.
        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q[gi] <= '0;
            end else if (accept[gi] && !grant[gi]) begin
                pend_q[gi] <= pend_q[gi] + 1'b1;
            end else if (grant[gi] && !accept[gi]) begin
                pend_q[gi] <= pend_q[gi] - 1'b1;
            end
        end
    end

    // Stay on the last port while its burst allowance lasts; otherwise scan forward from
    // last+1, wrapping round so that last itself is the final candidate.
    always_comb begin
        int idx;
        idx    = 0;
        pick_d = last_q;
        if (!(nonzero[last_q] && (burst_q < WEIGHT_B))) begin
            for (int k = S_COUNT; k >= 1; k--) begin
                idx = (int'(last_q) + k) % S_COUNT;
                if (nonzero[idx]) begin
                    pick_d = SELECTOR_WIDTH'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            sel_q    <= '0;
            last_q   <= SELECTOR_WIDTH'(S_COUNT - 1);
            burst_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|nonzero) begin
                        sel_q    <= pick_d;
                        tvalid_q <= 1'b1;
                        state_q  <= OFFER;
                    end
                end
                OFFER: begin
                    if (sched_if.m_sel_tready) begin
                        tvalid_q <= 1'b0;
                        state_q  <= IDLE;
                        last_q   <= sel_q;
                        if (sel_q != last_q) begin
                            burst_q <= 8'd1;
                        end else if (burst_q < WEIGHT_B) begin
                            burst_q <= burst_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [31:0] grants_q [S_COUNT];

    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_stat
        always_ff @(posedge clk) begin
            if (rst) begin
                grants_q[gi] <= '0;
            end else if (grant[gi]) begin
                grants_q[gi] <= grants_q[gi] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        if (32'(stat_idx) < S_COUNT) begin
            stat_grants = grants_q[stat_idx];
        end
    end
`endif
endmodule

// File: tb/tb_ctrl_mux_sched.sv
// Directed bench for ctrl_mux_sched: expected tokens go into a scoreboard queue that a
// negedge monitor drains on every selector handshake; level checks run inline.
module tb_ctrl_mux_sched;
    localparam int S  = 3;
    localparam int SW = 2;
    localparam int PW = 4;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_mux_sched_if #(.S_COUNT(S), .SELECTOR_WIDTH(SW), .PEND_WIDTH(PW)) bus ();

`ifdef SCHED_STATS_EN
    logic [SW-1:0] stat_idx;
    logic [31:0]   stat_grants;
`endif

    ctrl_mux_sched #(
        .S_COUNT(S), .SELECTOR_WIDTH(SW), .PEND_WIDTH(PW), .WEIGHT(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sched_if(bus)
`ifdef SCHED_STATS_EN
        ,
        .stat_idx(stat_idx),
        .stat_grants(stat_grants)
`endif
    );

    int checks   = 0;
    int failures = 0;
    logic [SW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    function automatic logic [31:0] pend(input int i);
        return 32'(bus.pending_cnt[i*PW +: PW]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.s_req_valid  = '0;
        bus.m_sel_tready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.m_sel_tvalid && bus.m_sel_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL token_unexpected actual=%0d required=none", bus.m_sel_tdata);
            end else begin
                logic [SW-1:0] e;
                e = exp_q.pop_front();
                chk("token", 32'(bus.m_sel_tdata), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;
        int n;
        bus.s_req_valid  = '0;
        bus.m_sel_tready = 1'b0;
`ifdef SCHED_STATS_EN
        stat_idx = '0;
`endif
        repeat (3) step();
        rst = 1'b0;

        chk("reset_tvalid", 32'(bus.m_sel_tvalid), 0);
        chk("reset_tdata", 32'(bus.m_sel_tdata), 0);
        chk("reset_pending", 32'(bus.pending_cnt), 0);
        chk("reset_ready", 32'(bus.s_req_ready), 32'b111);

        // Single event on port 1: tvalid two cycles after acceptance.
        bus.s_req_valid = 3'b010;
        step();
        bus.s_req_valid = '0;
        chk("single_tvalid_n1", 32'(bus.m_sel_tvalid), 0);
        chk("single_pend1_n1", pend(1), 1);
        step();
        chk("single_tvalid_n2", 32'(bus.m_sel_tvalid), 1);
        chk("single_tdata_n2", 32'(bus.m_sel_tdata), 1);
        exp_q.push_back(2'd1);
        step();
        chk("single_tvalid_hold", 32'(bus.m_sel_tvalid), 1);
        step();
        bus.m_sel_tready = 1'b1;
        step();
        bus.m_sel_tready = 1'b0;
        chk("single_tvalid_after", 32'(bus.m_sel_tvalid), 0);
        chk("single_pend1_after", pend(1), 0);

        // Saturate port 0 with 16 events while the token is held.
        apply_reset();
        accepted = 0;
        bus.s_req_valid = 3'b001;
        repeat (16) begin
            if (bus.s_req_ready[0]) accepted++;
            step();
        end
        bus.s_req_valid = '0;
        chk("sat_accepted", 32'(accepted), 15);
        chk("sat_pend0", pend(0), 15);
        chk("sat_ready0_low", 32'(bus.s_req_ready[0]), 0);
        chk("sat_offer_tdata", 32'(bus.m_sel_tdata), 0);
        exp_q.push_back(2'd0);
        bus.m_sel_tready = 1'b1;
        chk("sat_ready0_in_hs", 32'(bus.s_req_ready[0]), 0);
        step();
        bus.m_sel_tready = 1'b0;
        chk("sat_ready0_back", 32'(bus.s_req_ready[0]), 1);
        chk("sat_pend0_after", pend(0), 14);

        // Simultaneous arrival and grant on port 2 leave the count unchanged.
        apply_reset();
        bus.s_req_valid = 3'b100;
        repeat (3) step();
        chk("both_pend2_pre", pend(2), 3);
        chk("both_tvalid_pre", 32'(bus.m_sel_tvalid), 1);
        chk("both_tdata_pre", 32'(bus.m_sel_tdata), 2);
        exp_q.push_back(2'd2);
        bus.m_sel_tready = 1'b1;
        step();
        bus.s_req_valid  = '0;
        bus.m_sel_tready = 1'b0;
        chk("both_pend2_post", pend(2), 3);
        chk("both_tvalid_post", 32'(bus.m_sel_tvalid), 0);

        // Reset during an offer discards the token; simultaneous req/tready ignored.
        apply_reset();
        bus.s_req_valid = 3'b010;
        step();
        bus.s_req_valid = '0;
        step();
        chk("rstoffer_tdata", 32'(bus.m_sel_tdata), 1);
        rst = 1'b1;
        bus.m_sel_tready = 1'b1;
        bus.s_req_valid  = 3'b010;
        step();
        rst = 1'b0;
        bus.m_sel_tready = 1'b0;
        bus.s_req_valid  = '0;
        chk("rstoffer_tvalid", 32'(bus.m_sel_tvalid), 0);
        chk("rstoffer_pending", 32'(bus.pending_cnt), 0);
        chk("rstoffer_ready", 32'(bus.s_req_ready), 32'b111);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstoffer_no_reoffer", 32'(bus.m_sel_tvalid), 0);
        end

        // Weighted order: port 0 loaded first, then port 1, tready held high.
        apply_reset();
        bus.m_sel_tready = 1'b1;
        exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
        exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        bus.s_req_valid = 3'b001;
        repeat (6) step();
        bus.s_req_valid = 3'b010;
        repeat (6) step();
        bus.s_req_valid = '0;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        chk("wrr_drained", 32'(exp_q.size()), 0);
        step();
        bus.m_sel_tready = 1'b0;
        step();
        chk("wrr_pending_empty", 32'(bus.pending_cnt), 0);
        chk("wrr_tvalid_idle", 32'(bus.m_sel_tvalid), 0);
`ifdef SCHED_STATS_EN
        stat_idx = 2'd0; #1;
        chk("stat_port0", stat_grants, 6);
        stat_idx = 2'd1; #1;
        chk("stat_port1", stat_grants, 6);
        stat_idx = 2'd2; #1;
        chk("stat_port2", stat_grants, 0);
        stat_idx = 2'd3; #1;
        chk("stat_out_of_range", stat_grants, 0);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
